// File: rtl/uart_echo_fifo.sv
// UART echo with an RX byte FIFO, a per-byte case transform and a periodic banner.
// uart_rx / uart_tx are the serialisers; uart_echo_fifo is the top.

module uart_rx #(
    parameter int unsigned CLK_FRE   = 50_000_000,
    parameter int unsigned BAUD_RATE = 57600
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    input  logic       rx_pin
);
    localparam int unsigned CYCLE = CLK_FRE / BAUD_RATE;
    localparam int unsigned CW    = $clog2(CYCLE);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d;
    logic          meta_q, sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_data_ready;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!sync_q) state_d = StStart;
            end
            // Re-check the line at mid start bit to reject glitches.
            StStart: if (cnt_q == CW'(CYCLE / 2 - 1)) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync_q ? StIdle : StData;
            end
            StData: if (cnt_q == CW'(CYCLE - 1)) begin
                cnt_d   = '0;
                shift_d = {sync_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = StStop;
            end
            StStop: if (cnt_q == CW'(CYCLE - 1)) begin
                state_d = StIdle;
                if (sync_q) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            meta_q  <= rx_pin;
            sync_q  <= meta_q;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
endmodule

module uart_tx #(
    parameter int unsigned CLK_FRE   = 50_000_000,
    parameter int unsigned BAUD_RATE = 57600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);
    localparam int unsigned CYCLE = CLK_FRE / BAUD_RATE;
    localparam int unsigned CW    = $clog2(CYCLE);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          pin_q, pin_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pin_d   = pin_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (tx_data_valid) begin
                    state_d = StStart;
                    shift_d = tx_data;
                    pin_d   = 1'b0;
                end
            end
            StStart: if (cnt_q == CW'(CYCLE - 1)) begin
                state_d = StData;
                cnt_d   = '0;
                bit_d   = '0;
                pin_d   = shift_q[0];
                shift_d = shift_q >> 1;
            end
            StData: if (cnt_q == CW'(CYCLE - 1)) begin
                cnt_d = '0;
                if (bit_q == 3'd7) begin
                    state_d = StStop;
                    pin_d   = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    pin_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            StStop: if (cnt_q == CW'(CYCLE - 1)) state_d = StIdle;
            default: begin
                state_d = StIdle;
                pin_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
        end
    end

    assign tx_data_ready = (state_q == StIdle);
    assign tx_pin        = pin_q;
endmodule

module uart_echo_fifo #(
    parameter int unsigned            CLK_FRE       = 50_000_000,
    parameter int unsigned            UART_FRE      = 57600,
    parameter int unsigned            FIFO_DEPTH    = 16,
    parameter int unsigned            MSG_LEN       = 15,
    parameter logic [MSG_LEN*8-1:0]   MSG           = {"Tang Nano 20K", 8'h0d, 8'h0a},
    parameter int unsigned            BANNER_PERIOD = CLK_FRE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    input  logic [1:0]                    case_mode,
    input  logic                          banner_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned IW = $clog2(MSG_LEN + 1);
    localparam int unsigned PW = $clog2(BANNER_PERIOD);

    typedef enum logic [1:0] {StIdle = 2'd0, StBanner = 2'd1, StEcho = 2'd2} state_e;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       tx_data_ready;

    uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_FRE)) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (1'b1),
        .rx_pin        (uart_rx)
    );

    state_e        state_q, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] period_q, period_d;

    logic [MSG_LEN*8-1:0] msg_sh;
    logic [7:0]           banner_byte;
    logic                 fifo_empty, fifo_full, tx_idle, handshake, pop, push, period_tick;

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] mode);
        logic is_up, is_lo;
        is_up = (b >= 8'h41) && (b <= 8'h5a);
        is_lo = (b >= 8'h61) && (b <= 8'h7a);
        unique case (mode)
            2'd1:    return is_up ? (b | 8'h20) : b;
            2'd2:    return is_lo ? (b & 8'hdf) : b;
            2'd3:    return (is_up || is_lo) ? (b ^ 8'h20) : b;
            default: return b;
        endcase
    endfunction

    assign msg_sh      = MSG << {idx_q, 3'b000};
    assign banner_byte = msg_sh[MSG_LEN*8-1 -: 8];

    assign fifo_empty  = (level_q == '0);
    assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
    assign tx_idle     = !tx_valid_q && tx_data_ready;
    assign handshake   = tx_valid_q && tx_data_ready;
    assign pop         = (state_q == StEcho) && tx_idle && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push        = rx_data_valid && (!fifo_full || pop);
    assign period_tick = (state_q == StEcho) && fifo_empty && tx_idle && banner_en;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        idx_d      = idx_q;
        period_d   = period_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        if (rx_data_valid && fifo_full && !pop) overflow_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                state_d  = banner_en ? StBanner : StEcho;
                idx_d    = '0;
                period_d = '0;
            end
            // banner_en is ignored here so a started banner always completes.
            StBanner: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == IW'(MSG_LEN - 1)) begin
                        state_d  = StEcho;
                        idx_d    = '0;
                        period_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = banner_byte;
                end
            end
            StEcho: begin
                if (handshake) tx_valid_d = 1'b0;
                if (pop) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = xform(mem[rd_ptr_q], case_mode);
                    period_d   = '0;
                end else if (period_tick) begin
                    if (period_q == PW'(BANNER_PERIOD - 1)) begin
                        state_d  = StBanner;
                        period_d = '0;
                    end else begin
                        period_d = period_q + PW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            idx_q      <= '0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            idx_q      <= idx_d;
            period_q   <= period_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

    uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_FRE)) u_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data_q),
        .tx_data_valid (tx_valid_q),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (uart_tx)
    );

    assign fifo_level = level_q;
    assign overflow   = overflow_q;
endmodule
